// File: rtl/pipe_ctrl_unit.sv
// Pipelined control unit: decodes ID, carries controls through ID/EX, EX/MEM and MEM/WB, and sequences halt.
// Latency: controls reach EX 1 edge, MEM 2 edges and WB 3 edges after ID capture; halted rises 1 edge after HLT sits in WB.
// Backpressure: ext_stall freezes all stage and halt state; a load-use hazard holds ID and injects one bubble into EX.
module pipe_ctrl_unit #(
  parameter int INSTR_W         = 16,
  parameter int OPC_W           = 4,
  parameter int REG_IDX_W       = 4,
  parameter int ZERO_REG_EXEMPT = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [INSTR_W-1:0]   id_instr,
  input  logic                 id_valid,
  input  logic                 flush,
  input  logic                 ext_stall,
  output logic                 stall,
  output logic                 ex_alu_src,
  output logic                 ex_reg_dst,
  output logic [1:0]           ex_branch,
  output logic                 ex_pcs,
  output logic [REG_IDX_W-1:0] ex_rd,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic                 wb_reg_write,
  output logic                 wb_mem_to_reg,
  output logic [REG_IDX_W-1:0] wb_rd,
  output logic                 halt_fetch,
  output logic                 halted
);

  // Field positions: opcode at the top, then rd, rs, rt.
  localparam int RD_LSB = INSTR_W - OPC_W - REG_IDX_W;
  localparam int RS_LSB = RD_LSB - REG_IDX_W;
  localparam int RT_LSB = RS_LSB - REG_IDX_W;
  localparam bit ZERO_EXEMPT = (ZERO_REG_EXEMPT != 0);

  localparam logic [OPC_W-1:0] OP_ADD    = OPC_W'(0);
  localparam logic [OPC_W-1:0] OP_SUB    = OPC_W'(1);
  localparam logic [OPC_W-1:0] OP_XOR    = OPC_W'(2);
  localparam logic [OPC_W-1:0] OP_RED    = OPC_W'(3);
  localparam logic [OPC_W-1:0] OP_SLL    = OPC_W'(4);
  localparam logic [OPC_W-1:0] OP_SRA    = OPC_W'(5);
  localparam logic [OPC_W-1:0] OP_ROR    = OPC_W'(6);
  localparam logic [OPC_W-1:0] OP_PADDSB = OPC_W'(7);
  localparam logic [OPC_W-1:0] OP_LW     = OPC_W'(8);
  localparam logic [OPC_W-1:0] OP_SW     = OPC_W'(9);
  localparam logic [OPC_W-1:0] OP_LLB    = OPC_W'(10);
  localparam logic [OPC_W-1:0] OP_LHB    = OPC_W'(11);
  localparam logic [OPC_W-1:0] OP_B      = OPC_W'(12);
  localparam logic [OPC_W-1:0] OP_BR     = OPC_W'(13);
  localparam logic [OPC_W-1:0] OP_PCS    = OPC_W'(14);
  localparam logic [OPC_W-1:0] OP_HLT    = OPC_W'(15);

  // Each stage register keeps only the controls still needed downstream.
  // rd is the raw instruction rd field; the halt token rides with the WB group.
  typedef struct packed {
    logic                 regWrite;
    logic                 memToReg;
    logic                 halt;
    logic [REG_IDX_W-1:0] rd;
  } wbCtrl_t;

  typedef struct packed {
    logic    memRead;
    logic    memWrite;
    wbCtrl_t wb;
  } memCtrl_t;

  typedef struct packed {
    logic     aluSrc;
    logic     regDst;
    logic [1:0] branch;
    logic     pcs;
    memCtrl_t mem;
  } exCtrl_t;

  typedef enum logic [1:0] {
    HS_RUN,
    HS_DRAIN,
    HS_HALTED
  } haltState_t;

  logic [OPC_W-1:0]     idOpc;
  logic [REG_IDX_W-1:0] idRd;
  logic [REG_IDX_W-1:0] idRs;
  logic [REG_IDX_W-1:0] idRt;

  exCtrl_t    decCtrl;
  exCtrl_t    idExNext;
  exCtrl_t    idEx;
  memCtrl_t   exMem;
  wbCtrl_t    memWb;
  haltState_t haltState;
  haltState_t haltNext;

  logic useRs;
  logic useRt;
  logic useRd;
  logic hitRs;
  logic hitRt;
  logic hitRd;
  logic idLive;
  logic loadUse;
  logic issue;

  assign idOpc = id_instr[INSTR_W-1 -: OPC_W];
  assign idRd  = id_instr[RD_LSB +: REG_IDX_W];
  assign idRs  = id_instr[RS_LSB +: REG_IDX_W];
  assign idRt  = id_instr[RT_LSB +: REG_IDX_W];

  // Decode the ID opcode into controls and the set of source registers it reads.
  always_comb begin
    decCtrl           = '0;
    decCtrl.mem.wb.rd = idRd;
    useRs             = 1'b0;
    useRt             = 1'b0;
    useRd             = 1'b0;
    case (idOpc)
      OP_ADD, OP_SUB, OP_XOR, OP_RED, OP_PADDSB: begin
        decCtrl.regDst          = 1'b1;
        decCtrl.mem.wb.regWrite = 1'b1;
        useRs                   = 1'b1;
        useRt                   = 1'b1;
      end
      OP_SLL, OP_SRA, OP_ROR: begin
        decCtrl.regDst          = 1'b1;
        decCtrl.mem.wb.regWrite = 1'b1;
        useRs                   = 1'b1;
      end
      OP_LW: begin
        decCtrl.aluSrc          = 1'b1;
        decCtrl.mem.memRead     = 1'b1;
        decCtrl.mem.wb.memToReg = 1'b1;
        decCtrl.mem.wb.regWrite = 1'b1;
        useRs                   = 1'b1;
      end
      OP_SW: begin
        // rd carries the store data, so it is a source here.
        decCtrl.aluSrc       = 1'b1;
        decCtrl.mem.memWrite = 1'b1;
        useRs                = 1'b1;
        useRd                = 1'b1;
      end
      OP_LLB, OP_LHB: begin
        // Byte loads merge into the old rd value, so rd is read as well as written.
        decCtrl.aluSrc          = 1'b1;
        decCtrl.mem.wb.regWrite = 1'b1;
        useRd                   = 1'b1;
      end
      OP_B: begin
        decCtrl.branch = 2'b11;
      end
      OP_BR: begin
        decCtrl.branch = 2'b10;
        useRs          = 1'b1;
      end
      OP_PCS: begin
        decCtrl.pcs             = 1'b1;
        decCtrl.mem.wb.regWrite = 1'b1;
      end
      OP_HLT: begin
        decCtrl.mem.wb.halt = 1'b1;
      end
      default: ;
    endcase
  end

  // Load-use detection against the load sitting in EX; r0 can be exempted as it never changes.
  assign hitRs = useRs && (idRs == idEx.mem.wb.rd) && (!ZERO_EXEMPT || (idRs != '0));
  assign hitRt = useRt && (idRt == idEx.mem.wb.rd) && (!ZERO_EXEMPT || (idRt != '0));
  assign hitRd = useRd && (idRd == idEx.mem.wb.rd) && (!ZERO_EXEMPT || (idRd != '0));

  // Once fetch is stopped, whatever sits in ID is stale and must not issue.
  assign idLive  = id_valid && (haltState == HS_RUN);
  assign loadUse = idLive && idEx.mem.memRead && (hitRs || hitRt || hitRd);
  // A flush discards the ID instruction anyway, so holding it would be pointless.
  assign stall   = loadUse && !flush;
  assign issue   = idLive && !flush && !loadUse;
  assign idExNext = issue ? decCtrl : '0;

  // Stage registers: reset to bubbles, freeze on ext_stall, otherwise advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      idEx  <= '0;
      exMem <= '0;
      memWb <= '0;
    end else if (!ext_stall) begin
      idEx  <= idExNext;
      exMem <= idEx.mem;
      memWb <= exMem.wb;
    end
  end

  // Halt state register; only reset leaves the drain/halted states.
  always_ff @(posedge clk) begin
    if (rst) begin
      haltState <= HS_RUN;
    end else begin
      haltState <= haltNext;
    end
  end

  // Halt sequencing: stop fetch when HLT issues, flag halted once the token has been in WB.
  always_comb begin
    haltNext = haltState;
    if (!ext_stall) begin
      case (haltState)
        HS_RUN: begin
          if (issue && decCtrl.mem.wb.halt) begin
            haltNext = HS_DRAIN;
          end
        end
        HS_DRAIN: begin
          if (memWb.halt) begin
            haltNext = HS_HALTED;
          end
        end
        HS_HALTED: ;
        default: ;
      endcase
    end
  end

  assign ex_alu_src    = idEx.aluSrc;
  assign ex_reg_dst    = idEx.regDst;
  assign ex_branch     = idEx.branch;
  assign ex_pcs        = idEx.pcs;
  assign ex_rd         = idEx.mem.wb.rd;
  assign mem_read      = exMem.memRead;
  assign mem_write     = exMem.memWrite;
  assign wb_reg_write  = memWb.regWrite;
  assign wb_mem_to_reg = memWb.memToReg;
  assign wb_rd         = memWb.rd;
  assign halt_fetch    = (haltState != HS_RUN);
  assign halted        = (haltState == HS_HALTED);

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Bench for pipe_ctrl_unit: directed scenarios plus a randomized run against an instruction-level pipeline model.
// Two DUT copies share inputs: one with r0 exempt from hazards, one without.
// Inputs change 2 time units after each rising edge; outputs are sampled before the next edge.
module tb_pipe_ctrl_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [15:0] idInstr;
  logic        idValid;
  logic        flush;
  logic        extStall;

  // DUT with r0 exempt
  logic       stall, exAluSrc, exRegDst, exPcs, memRead, memWrite, wbRegWrite, wbMemToReg, haltFetch, halted;
  logic [1:0] exBranch;
  logic [3:0] exRd, wbRd;
  // DUT without r0 exemption
  logic       nStall, nExAluSrc, nExRegDst, nExPcs, nMemRead, nMemWrite, nWbRegWrite, nWbMemToReg, nHaltFetch, nHalted;
  logic [1:0] nExBranch;
  logic [3:0] nExRd, nWbRd;

  logic [18:0] obsA, obsB;
  logic [31:0] got, want;
  int checks = 0;
  int passed = 0;

  pipe_ctrl_unit #(.ZERO_REG_EXEMPT(1)) dut (
    .clk(clk), .rst(rst), .id_instr(idInstr), .id_valid(idValid), .flush(flush), .ext_stall(extStall),
    .stall(stall), .ex_alu_src(exAluSrc), .ex_reg_dst(exRegDst), .ex_branch(exBranch), .ex_pcs(exPcs),
    .ex_rd(exRd), .mem_read(memRead), .mem_write(memWrite), .wb_reg_write(wbRegWrite),
    .wb_mem_to_reg(wbMemToReg), .wb_rd(wbRd), .halt_fetch(haltFetch), .halted(halted)
  );

  pipe_ctrl_unit #(.ZERO_REG_EXEMPT(0)) dutNoEx (
    .clk(clk), .rst(rst), .id_instr(idInstr), .id_valid(idValid), .flush(flush), .ext_stall(extStall),
    .stall(nStall), .ex_alu_src(nExAluSrc), .ex_reg_dst(nExRegDst), .ex_branch(nExBranch), .ex_pcs(nExPcs),
    .ex_rd(nExRd), .mem_read(nMemRead), .mem_write(nMemWrite), .wb_reg_write(nWbRegWrite),
    .wb_mem_to_reg(nWbMemToReg), .wb_rd(nWbRd), .halt_fetch(nHaltFetch), .halted(nHalted)
  );

  assign obsA = {exAluSrc, exRegDst, exBranch, exPcs, exRd, memRead, memWrite,
                 wbRegWrite, wbMemToReg, wbRd, haltFetch, halted};
  assign obsB = {nExAluSrc, nExRegDst, nExBranch, nExPcs, nExRd, nMemRead, nMemWrite,
                 nWbRegWrite, nWbMemToReg, nWbRd, nHaltFetch, nHalted};

  // ---------------- reference model ----------------
  typedef struct packed {
    logic       aluSrc;
    logic       regDst;
    logic [1:0] br;
    logic       pcs;
    logic       memRead;
    logic       memWrite;
    logic       regWrite;
    logic       memToReg;
  } ctl_t;

  typedef struct packed {
    logic       v;
    logic [3:0] opc;
    logic [3:0] rd;
  } slot_t;

  slot_t mEx[2], mMem[2], mWb[2];
  bit    mHf[2], mHd[2];

  function automatic logic [15:0] mk(input int opc, input int rd, input int rs, input int rt);
    return {opc[3:0], rd[3:0], rs[3:0], rt[3:0]};
  endfunction

  // Control table per opcode.
  function automatic ctl_t ctlOf(input logic [3:0] opc);
    ctl_t c;
    c = '0;
    if (opc <= 4'd7) begin
      c.regDst = 1'b1; c.regWrite = 1'b1;
    end else begin
      case (opc)
        4'd8:         begin c.aluSrc = 1'b1; c.memRead = 1'b1; c.memToReg = 1'b1; c.regWrite = 1'b1; end
        4'd9:         begin c.aluSrc = 1'b1; c.memWrite = 1'b1; end
        4'd10, 4'd11: begin c.aluSrc = 1'b1; c.regWrite = 1'b1; end
        4'd12:        c.br = 2'b11;
        4'd13:        c.br = 2'b10;
        4'd14:        begin c.pcs = 1'b1; c.regWrite = 1'b1; end
        default:      ;
      endcase
    end
    return c;
  endfunction

  // True when instruction ins reads register r (subject to r0 exemption).
  function automatic bit srcHit(input logic [15:0] ins, input logic [3:0] r, input bit exempt);
    logic [3:0] opc;
    logic [3:0] srcs[$];
    opc = ins[15:12];
    if (opc <= 4'd3 || opc == 4'd7) begin
      srcs.push_back(ins[7:4]); srcs.push_back(ins[3:0]);
    end else if (opc <= 4'd6 || opc == 4'd8 || opc == 4'd13) begin
      srcs.push_back(ins[7:4]);
    end else if (opc == 4'd9) begin
      srcs.push_back(ins[7:4]); srcs.push_back(ins[11:8]);
    end else if (opc == 4'd10 || opc == 4'd11) begin
      srcs.push_back(ins[11:8]);
    end
    if (exempt && r == 4'd0) return 1'b0;
    foreach (srcs[i]) if (srcs[i] == r) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [18:0] expVec(input int k);
    ctl_t ce, cm, cw;
    ce = mEx[k].v  ? ctlOf(mEx[k].opc)  : '0;
    cm = mMem[k].v ? ctlOf(mMem[k].opc) : '0;
    cw = mWb[k].v  ? ctlOf(mWb[k].opc)  : '0;
    return {ce.aluSrc, ce.regDst, ce.br, ce.pcs, (mEx[k].v ? mEx[k].rd : 4'd0), cm.memRead, cm.memWrite,
            cw.regWrite, cw.memToReg, (mWb[k].v ? mWb[k].rd : 4'd0), mHf[k], mHd[k]};
  endfunction

  function automatic logic [15:0] randInstr();
    int opc;
    opc = $urandom_range(0, 15);
    if (opc == 15 && $urandom_range(0, 9) != 0) opc = 8;
    if ($urandom_range(0, 3) == 0) opc = 8;
    return mk(opc, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
  endfunction

  // ---------------- helpers for stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic doReset();
    rst = 1'b1; idValid = 1'b0; flush = 1'b0; extStall = 1'b0; idInstr = '0;
    tick();
    rst = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; idValid = 1'b1; idInstr = mk(8, 1, 1, 1); flush = 1'b0; extStall = 1'b0;
    tick(); tick();
    checks++; if (obsA !== 19'd0) $display("FAIL reset_outs_a got %h want 0", obsA); else passed++;
    checks++; if (obsB !== 19'd0) $display("FAIL reset_outs_b got %h want 0", obsB); else passed++;
    checks++; if ({stall, nStall} !== 2'b00) $display("FAIL reset_stall got %b want 00", {stall, nStall}); else passed++;
    rst = 1'b0; idValid = 1'b0;
  endtask

  task automatic test_back_to_back();
    doReset();
    idValid = 1'b1; idInstr = mk(0, 1, 2, 3);
    tick();
    got = {exRegDst, exAluSrc, exRd}; want = {1'b1, 1'b0, 4'd1};
    checks++; if (got !== want) $display("FAIL b2b_e1_ex got %h want %h", got, want); else passed++;
    idInstr = mk(8, 4, 5, 0);
    #1;
    checks++; if (stall !== 1'b0) $display("FAIL b2b_no_stall got %b want 0", stall); else passed++;
    tick();
    got = {exAluSrc, exRegDst, exRd, memRead}; want = {1'b1, 1'b0, 4'd4, 1'b0};
    checks++; if (got !== want) $display("FAIL b2b_e2 got %h want %h", got, want); else passed++;
    idValid = 1'b0;
    tick();
    got = {wbRegWrite, wbMemToReg, wbRd, memRead}; want = {1'b1, 1'b0, 4'd1, 1'b1};
    checks++; if (got !== want) $display("FAIL b2b_e3_wb got %h want %h", got, want); else passed++;
    tick();
    got = {wbRegWrite, wbMemToReg, wbRd}; want = {1'b1, 1'b1, 4'd4};
    checks++; if (got !== want) $display("FAIL b2b_e4_wb got %h want %h", got, want); else passed++;
  endtask

  task automatic test_load_use();
    doReset();
    idValid = 1'b1; idInstr = mk(8, 2, 7, 0);
    tick();
    idInstr = mk(0, 3, 2, 1);
    #1;
    checks++; if (stall !== 1'b1) $display("FAIL lu_stall got %b want 1", stall); else passed++;
    tick();
    got = {exRegDst, exAluSrc, exRd, memRead, stall}; want = {1'b0, 1'b0, 4'd0, 1'b1, 1'b0};
    checks++; if (got !== want) $display("FAIL lu_bubble got %h want %h", got, want); else passed++;
    tick();
    got = {exRegDst, exRd}; want = {1'b1, 4'd3};
    checks++; if (got !== want) $display("FAIL lu_issue got %h want %h", got, want); else passed++;

    doReset();
    idValid = 1'b1; idInstr = mk(8, 0, 7, 0);
    tick();
    idInstr = mk(0, 3, 0, 1);
    #1;
    got = {stall, nStall}; want = 2'b01;
    checks++; if (got !== want) $display("FAIL lu_r0 got %b want %b", got[1:0], want[1:0]); else passed++;
    tick();
    got = {exRegDst, exRd, nExRegDst, nExRd}; want = {1'b1, 4'd3, 1'b0, 4'd0};
    checks++; if (got !== want) $display("FAIL lu_r0_ex got %h want %h", got, want); else passed++;

    doReset();
    idValid = 1'b1; idInstr = mk(8, 6, 1, 0);
    tick();
    idInstr = mk(9, 6, 1, 0);
    #1;
    checks++; if (stall !== 1'b1) $display("FAIL lu_sw_rd got %b want 1", stall); else passed++;
    idInstr = mk(12, 6, 6, 6);
    #1;
    checks++; if (stall !== 1'b0) $display("FAIL lu_branch got %b want 0", stall); else passed++;
    idValid = 1'b0;
  endtask

  task automatic test_flush();
    doReset();
    idValid = 1'b1; idInstr = mk(8, 2, 7, 0);
    tick();
    idInstr = mk(0, 3, 2, 1); flush = 1'b1;
    #1;
    checks++; if (stall !== 1'b0) $display("FAIL fl_stall got %b want 0", stall); else passed++;
    tick();
    got = {exRegDst, exAluSrc, exRd, memRead}; want = {1'b0, 1'b0, 4'd0, 1'b1};
    checks++; if (got !== want) $display("FAIL fl_bubble got %h want %h", got, want); else passed++;
    flush = 1'b0; idValid = 1'b0;
    tick();
    got = {exRegDst, exRd, wbMemToReg, wbRd}; want = {1'b0, 4'd0, 1'b1, 4'd2};
    checks++; if (got !== want) $display("FAIL fl_discard got %h want %h", got, want); else passed++;
    idValid = 1'b1; idInstr = mk(15, 0, 0, 0); flush = 1'b1;
    tick();
    checks++; if (haltFetch !== 1'b0) $display("FAIL fl_hlt got %b want 0", haltFetch); else passed++;
    flush = 1'b0; idValid = 1'b0;
    repeat (4) tick();
    got = {haltFetch, halted}; want = 2'b00;
    checks++; if (got !== want) $display("FAIL fl_hlt_drain got %b want 00", got[1:0]); else passed++;
  endtask

  task automatic test_ext_stall();
    doReset();
    idValid = 1'b1; idInstr = mk(8, 4, 5, 0);
    tick();
    idInstr = mk(0, 3, 4, 1); extStall = 1'b1;
    #1;
    checks++; if (stall !== 1'b1) $display("FAIL es_stall_comb got %b want 1", stall); else passed++;
    tick();
    got = {exAluSrc, exRd, memRead, exRegDst}; want = {1'b1, 4'd4, 1'b0, 1'b0};
    checks++; if (got !== want) $display("FAIL es_frozen_lu got %h want %h", got, want); else passed++;
    extStall = 1'b0;
    tick();
    got = {exRegDst, exRd, memRead}; want = {1'b0, 4'd0, 1'b1};
    checks++; if (got !== want) $display("FAIL es_bubble got %h want %h", got, want); else passed++;
    tick();
    got = {exRegDst, exRd, wbMemToReg, wbRd}; want = {1'b1, 4'd3, 1'b1, 4'd4};
    checks++; if (got !== want) $display("FAIL es_resume got %h want %h", got, want); else passed++;

    doReset();
    idValid = 1'b1; idInstr = mk(8, 4, 5, 0);
    tick();
    idInstr = mk(0, 1, 2, 3);
    tick();
    idInstr = mk(1, 7, 8, 9); extStall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      got = {memRead, exRegDst, exRd, wbRegWrite}; want = {1'b1, 1'b1, 4'd1, 1'b0};
      checks++; if (got !== want) $display("FAIL es_hold%0d got %h want %h", i, got, want); else passed++;
    end
    extStall = 1'b0; idValid = 1'b0;
    tick();
    got = {memRead, wbMemToReg, wbRd, exRegDst}; want = {1'b0, 1'b1, 4'd4, 1'b0};
    checks++; if (got !== want) $display("FAIL es_after1 got %h want %h", got, want); else passed++;
    tick();
    got = {wbRegWrite, wbMemToReg, wbRd}; want = {1'b1, 1'b0, 4'd1};
    checks++; if (got !== want) $display("FAIL es_after2 got %h want %h", got, want); else passed++;
  endtask

  task automatic test_halt();
    doReset();
    idValid = 1'b1; idInstr = mk(15, 0, 0, 0);
    tick();
    got = {haltFetch, halted}; want = 2'b10;
    checks++; if (got !== want) $display("FAIL hl_e1 got %b want 10", got[1:0]); else passed++;
    idInstr = mk(0, 1, 2, 3);
    tick();
    got = {exRegDst, exRd, haltFetch, halted}; want = {1'b0, 4'd0, 1'b1, 1'b0};
    checks++; if (got !== want) $display("FAIL hl_e2_ignore got %h want %h", got, want); else passed++;
    tick();
    got = {wbRegWrite, halted}; want = 2'b00;
    checks++; if (got !== want) $display("FAIL hl_e3 got %b want 00", got[1:0]); else passed++;
    tick();
    got = {haltFetch, halted}; want = 2'b11;
    checks++; if (got !== want) $display("FAIL hl_e4 got %b want 11", got[1:0]); else passed++;
    tick();
    got = {haltFetch, halted, wbRegWrite}; want = 3'b110;
    checks++; if (got !== want) $display("FAIL hl_sticky got %b want 110", got[2:0]); else passed++;

    doReset();
    idValid = 1'b1; idInstr = mk(15, 0, 0, 0);
    tick();
    idValid = 1'b0; extStall = 1'b1;
    tick();
    extStall = 1'b0;
    tick(); tick();
    checks++; if (halted !== 1'b0) $display("FAIL hl_es_early got %b want 0", halted); else passed++;
    tick();
    checks++; if (halted !== 1'b1) $display("FAIL hl_es_late got %b want 1", halted); else passed++;

    doReset();
    extStall = 1'b1; idValid = 1'b1; idInstr = mk(15, 0, 0, 0);
    tick();
    checks++; if (haltFetch !== 1'b0) $display("FAIL hl_frozen_id got %b want 0", haltFetch); else passed++;
    extStall = 1'b0;
    tick();
    checks++; if (haltFetch !== 1'b1) $display("FAIL hl_after_es got %b want 1", haltFetch); else passed++;

    doReset();
    idValid = 1'b1; idInstr = mk(15, 0, 0, 0);
    tick();
    idValid = 1'b0;
    tick();
    rst = 1'b1; extStall = 1'b1; flush = 1'b1; idValid = 1'b1; idInstr = mk(8, 1, 2, 3);
    tick();
    got = {obsA, stall}; want = '0;
    checks++; if (got !== want) $display("FAIL hl_rst_mid got %h want 0", got); else passed++;
    rst = 1'b0; extStall = 1'b0; flush = 1'b0; idValid = 1'b0;
    repeat (4) tick();
    got = {haltFetch, halted}; want = 2'b00;
    checks++; if (got !== want) $display("FAIL hl_rst_clear got %b want 00", got[1:0]); else passed++;
  endtask

  task automatic test_random();
    bit eff[2], lu[2], expSt[2];
    bit hold;
    doReset();
    for (int k = 0; k < 2; k++) begin
      mEx[k] = '0; mMem[k] = '0; mWb[k] = '0; mHf[k] = 1'b0; mHd[k] = 1'b0;
    end
    hold = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (!hold) idInstr = randInstr();
      idValid  = ($urandom_range(0, 7) != 0);
      flush    = ($urandom_range(0, 9) == 0);
      extStall = ($urandom_range(0, 6) == 0);
      rst      = ($urandom_range(0, 99) == 0) || (mHd[0] && $urandom_range(0, 5) == 0);
      for (int k = 0; k < 2; k++) begin
        eff[k]   = idValid && !mHf[k];
        lu[k]    = eff[k] && mEx[k].v && (mEx[k].opc == 4'd8) && srcHit(idInstr, mEx[k].rd, k == 0);
        expSt[k] = lu[k] && !flush;
      end
      #1;
      got = {stall, nStall}; want = {expSt[0], expSt[1]};
      checks++; if (got !== want) $display("FAIL rnd_stall c%0d got %b want %b", cyc, got[1:0], want[1:0]); else passed++;
      tick();
      for (int k = 0; k < 2; k++) begin
        if (rst) begin
          mEx[k] = '0; mMem[k] = '0; mWb[k] = '0; mHf[k] = 1'b0; mHd[k] = 1'b0;
        end else if (!extStall) begin
          if (mWb[k].v && mWb[k].opc == 4'd15) mHd[k] = 1'b1;
          mWb[k]  = mMem[k];
          mMem[k] = mEx[k];
          if (eff[k] && !flush && !lu[k]) begin
            mEx[k] = {1'b1, idInstr[15:12], idInstr[11:8]};
            if (idInstr[15:12] == 4'd15) mHf[k] = 1'b1;
          end else begin
            mEx[k] = '0;
          end
        end
      end
      checks++; if (obsA !== expVec(0)) $display("FAIL rnd_outs_a c%0d got %h want %h", cyc, obsA, expVec(0)); else passed++;
      checks++; if (obsB !== expVec(1)) $display("FAIL rnd_outs_b c%0d got %h want %h", cyc, obsB, expVec(1)); else passed++;
      hold = expSt[0] || extStall;
    end
    rst = 1'b0; idValid = 1'b0; flush = 1'b0; extStall = 1'b0;
  endtask

  initial begin
    rst = 1'b1; idInstr = '0; idValid = 1'b0; flush = 1'b0; extStall = 1'b0;
    test_reset();
    test_back_to_back();
    test_load_use();
    test_flush();
    test_ext_stall();
    test_halt();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
